// File: rtl/invmap_pkg.sv
`default_nettype none
// invmap_pkg: shared widths, entry field positions, owner and FSM encodings for the inverse-mapping table arbiter.
// The CLR state exists only when INVMAP_TABLE_CLEAR_EN is defined.
package invmap_pkg;

  localparam int INVMAP_ADDR_W = 8;
  localparam int INVMAP_DATA_W = 62;

  localparam int FLOWID_MSB = 61;
  localparam int FLOWID_LSB = 48;
  localparam int DMAC_MSB   = 47;

  typedef enum logic {
    OWN_LU  = 1'b0,
    OWN_CFG = 1'b1
  } owner_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LU      = 3'd1,
    ST_CFG_WR  = 3'd2,
    ST_CFG_RD  = 3'd3,
    ST_RD_WAIT = 3'd4
`ifdef INVMAP_TABLE_CLEAR_EN
    ,
    ST_CLR     = 3'd5
`endif
  } state_e;

  function automatic logic [INVMAP_DATA_W-1:0] make_entry(
    input logic [FLOWID_MSB-FLOWID_LSB:0] flowid,
    input logic [DMAC_MSB:0]              dmac
  );
    return {flowid, dmac};
  endfunction

endpackage : invmap_pkg
`default_nettype wire

// File: rtl/invmap_rd_wait_cnt.sv
`default_nettype none
// invmap_rd_wait_cnt: loadable RAM_LAT-cycle down-counter; done is high during the last wait cycle.
module invmap_rd_wait_cnt #(
  parameter int RAM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  localparam int CNT_W = (RAM_LAT < 2) ? 1 : $clog2(RAM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LAT);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= CNT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule : invmap_rd_wait_cnt
`default_nettype wire

// File: rtl/inversemapping_table_arbiter.sv
`default_nettype none
// inversemapping_table_arbiter: owns the inverse-mapping RAM port, alternating lookup sessions and config accesses.
// Optional table-clear sweep enabled by defining INVMAP_TABLE_CLEAR_EN.
module inversemapping_table_arbiter
  import invmap_pkg::*;
#(
  parameter int ADDR_W  = INVMAP_ADDR_W,
  parameter int DATA_W  = INVMAP_DATA_W,
  parameter int DEPTH   = 256,
  parameter int RAM_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_lu_req,
  output logic              o_lu_gnt,
  input  logic              i_lu_rd,
  input  logic [ADDR_W-1:0] iv_lu_raddr,
  output logic [DATA_W-1:0] ov_lu_rdata,
  output logic              o_lu_viol,
  input  logic              i_cfg_wr,
  input  logic              i_cfg_rd,
  input  logic [ADDR_W-1:0] iv_cfg_addr,
  input  logic [DATA_W-1:0] iv_cfg_wdata,
  output logic              o_cfg_ack,
  output logic [DATA_W-1:0] ov_cfg_rdata,
`ifdef INVMAP_TABLE_CLEAR_EN
  input  logic              i_cfg_clear,
  output logic              o_clr_busy,
`endif
  output logic              o_ram_rd,
  output logic              o_ram_wr,
  output logic [ADDR_W-1:0] ov_ram_addr,
  output logic [DATA_W-1:0] ov_ram_wdata,
  input  logic [DATA_W-1:0] iv_ram_rdata
);

  state_e            state_q;
  state_e            state_d;
  owner_e            owner_q;
  logic              lu_gnt_q;
  logic              viol_q;
  logic              ack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              cfg_req;
  logic              cfg_ok;
  logic              latch_cfg;
  logic              ack_set;
  logic              own_lu;
  logic              own_cfg;
  logic              capture;
  logic              cnt_start;
  logic              cnt_done;
  logic              ram_rd;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

`ifdef INVMAP_TABLE_CLEAR_EN
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);
  logic [ADDR_W:0] clr_cnt_q;
`endif

  // The ack cycle is excluded so the still-high level request is not taken twice.
  assign cfg_req = i_cfg_wr | i_cfg_rd;
  assign cfg_ok  = cfg_req && !ack_q && ((owner_q == OWN_LU) || !i_lu_req);

  invmap_rd_wait_cnt #(
    .RAM_LAT (RAM_LAT)
  ) u_rd_wait (
    .clk   (i_clk),
    .rst   (i_rst),
    .start (cnt_start),
    .done  (cnt_done)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    latch_cfg = 1'b0;
    ack_set   = 1'b0;
    own_lu    = 1'b0;
    own_cfg   = 1'b0;
    capture   = 1'b0;
    cnt_start = 1'b0;
    ram_rd    = 1'b0;
    ram_wr    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (state_q)
      ST_IDLE: begin
`ifdef INVMAP_TABLE_CLEAR_EN
        if (i_cfg_clear) begin
          state_d = ST_CLR;
        end else
`endif
        if (cfg_ok) begin
          latch_cfg = 1'b1;
          state_d   = i_cfg_wr ? ST_CFG_WR : ST_CFG_RD;
        end else if (i_lu_req) begin
          state_d = ST_LU;
        end
      end
      ST_LU: begin
        // Lookup engine drives the RAM directly so its read latency is unchanged.
        ram_rd   = i_lu_rd;
        ram_addr = iv_lu_raddr;
        if (!i_lu_req) begin
          own_lu  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_CFG_WR: begin
        ram_wr    = 1'b1;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        ack_set   = 1'b1;
        own_cfg   = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_CFG_RD: begin
        ram_rd    = 1'b1;
        ram_addr  = addr_q;
        cnt_start = 1'b1;
        state_d   = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (cnt_done) begin
          capture = 1'b1;
          ack_set = 1'b1;
          own_cfg = 1'b1;
          state_d = ST_IDLE;
        end
      end
`ifdef INVMAP_TABLE_CLEAR_EN
      ST_CLR: begin
        ram_wr   = 1'b1;
        ram_addr = clr_cnt_q[ADDR_W-1:0];
        if (clr_cnt_q == CLR_LAST) begin
          ack_set = 1'b1;
          own_cfg = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner_q  <= OWN_CFG;
      lu_gnt_q <= 1'b0;
      viol_q   <= 1'b0;
      ack_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      lu_gnt_q <= (state_d == ST_LU);
      ack_q    <= ack_set;
      if (i_lu_rd && !lu_gnt_q) begin
        viol_q <= 1'b1;
      end
      if (latch_cfg) begin
        addr_q  <= iv_cfg_addr;
        wdata_q <= iv_cfg_wdata;
      end
      if (capture) begin
        rdata_q <= iv_ram_rdata;
      end
      if (own_lu) begin
        owner_q <= OWN_LU;
      end else if (own_cfg) begin
        owner_q <= OWN_CFG;
      end
    end
  end

`ifdef INVMAP_TABLE_CLEAR_EN
  // One bit wider than the address so the sweep end is distinguishable from entry 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clr_cnt_q <= '0;
    end else if (state_q == ST_CLR) begin
      clr_cnt_q <= clr_cnt_q + 1'b1;
    end else begin
      clr_cnt_q <= '0;
    end
  end

  assign o_clr_busy = (state_q == ST_CLR);
`endif

  assign o_lu_gnt     = lu_gnt_q;
  assign o_lu_viol    = viol_q;
  assign o_cfg_ack    = ack_q;
  assign ov_cfg_rdata = rdata_q;
  assign ov_lu_rdata  = iv_ram_rdata;
  assign o_ram_rd     = ram_rd;
  assign o_ram_wr     = ram_wr;
  assign ov_ram_addr  = ram_addr;
  assign ov_ram_wdata = ram_wdata;

endmodule : inversemapping_table_arbiter
`default_nettype wire

// File: tb/tb_inversemapping_table_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// tb_inversemapping_table_arbiter: directed and randomized checks against a transaction-level table model.
module tb_inversemapping_table_arbiter;
  import invmap_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 62;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          lu_req, lu_rd, gnt, viol;
  logic [AW-1:0] lu_raddr, cfg_addr, ram_addr;
  logic [DW-1:0] lu_rdata, cfg_wdata, cfg_rdata, ram_wdata, ram_rdata;
  logic          cfg_wr, cfg_rd, ack, ram_rd, ram_wr;
`ifdef INVMAP_TABLE_CLEAR_EN
  logic          cfg_clear, clr_busy;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int wr_cnt = 0;
  int ack_cnt = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] s1, rdq;

  always #5 clk = ~clk;

  inversemapping_table_arbiter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_lu_req     (lu_req),
    .o_lu_gnt     (gnt),
    .i_lu_rd      (lu_rd),
    .iv_lu_raddr  (lu_raddr),
    .ov_lu_rdata  (lu_rdata),
    .o_lu_viol    (viol),
    .i_cfg_wr     (cfg_wr),
    .i_cfg_rd     (cfg_rd),
    .iv_cfg_addr  (cfg_addr),
    .iv_cfg_wdata (cfg_wdata),
    .o_cfg_ack    (ack),
    .ov_cfg_rdata (cfg_rdata),
`ifdef INVMAP_TABLE_CLEAR_EN
    .i_cfg_clear  (cfg_clear),
    .o_clr_busy   (clr_busy),
`endif
    .o_ram_rd     (ram_rd),
    .o_ram_wr     (ram_wr),
    .ov_ram_addr  (ram_addr),
    .ov_ram_wdata (ram_wdata),
    .iv_ram_rdata (ram_rdata)
  );

  // Single-port RAM with a two-cycle read latency
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      s1  <= '0;
      rdq <= '0;
    end else begin
      if (ram_wr) mem[ram_addr] <= ram_wdata;
      if (ram_rd) s1 <= mem[ram_addr];
      rdq <= s1;
    end
  end
  assign ram_rdata = rdq;

  always @(posedge clk) begin
    if (ram_wr) wr_cnt++;
    if (ack) ack_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; lu_req = 1'b0; lu_rd = 1'b0; lu_raddr = '0;
    cfg_wr = 1'b0; cfg_rd = 1'b0; cfg_addr = '0; cfg_wdata = '0;
`ifdef INVMAP_TABLE_CLEAR_EN
    cfg_clear = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // Level request held until ack, dropped the cycle after; exp_lat<0 skips the latency check
  task automatic cfg_op(input bit is_wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input int exp_lat);
    int n;
    int wr_seen;
    bit ad_ok;
    n = 0; wr_seen = 0; ad_ok = 1'b1;
    @(posedge clk); #1;
    cfg_wr = is_wr; cfg_rd = !is_wr; cfg_addr = a; cfg_wdata = d;
    forever begin
      @(negedge clk); n++;
      if (ram_wr) begin
        wr_seen++;
        if (ram_addr !== a || ram_wdata !== d) ad_ok = 1'b0;
      end
      if (ack || n > 2000) break;
    end
    check_eq("cfg_ack", ack, 1);
    if (exp_lat >= 0) check_eq("cfg_latency", n - 1, exp_lat);
    check_eq("cfg_ram_wr_count", wr_seen, is_wr ? 1 : 0);
    check_eq("cfg_ram_addr_data", ad_ok, 1);
    if (is_wr) ref_mem[a] = d;
    else check_eq("cfg_rdata", cfg_rdata, ref_mem[a]);
    @(posedge clk); #1 cfg_wr = 1'b0; cfg_rd = 1'b0;
    @(negedge clk);
    check_eq("cfg_ack_one_cycle", ack, 0);
  endtask

  task automatic lu_grant(output int lat);
    int n;
    n = 0;
    @(posedge clk); #1 lu_req = 1'b1;
    do begin @(negedge clk); n++; end while (!gnt && n < 2000);
    lat = gnt ? n : -1;
  endtask

  task automatic lu_end();
    @(posedge clk); #1 lu_req = 1'b0; lu_rd = 1'b0;
  endtask

  // Reads issued while granted; data checked two cycles later against the model
  task automatic lu_reads(input int cnt, input bit rnd, input logic [AW-1:0] base);
    logic v1, v2;
    logic [AW-1:0] a1, a2;
    v1 = 1'b0; v2 = 1'b0; a1 = '0; a2 = '0;
    for (int i = 0; i < cnt + 2; i++) begin
      @(posedge clk); #1;
      if (i < cnt) begin
        lu_rd    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        lu_raddr = rnd ? AW'($urandom_range(0, 15)) : AW'(int'(base) + i);
      end else begin
        lu_rd = 1'b0;
      end
      @(negedge clk);
      if (v2) check_eq("lu_rdata", lu_rdata, ref_mem[a2]);
      if (lu_rd) check_eq("lu_ram_addr", ram_addr, lu_raddr);
      check_eq("lu_ram_rd", ram_rd, lu_rd);
      v2 = v1; a2 = a1; v1 = lu_rd; a1 = lu_raddr;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, w0, a0, ctl_or, gnt_any;
    logic [DW-1:0] d;

    // Reset and idle
    do_reset();
    ctl_or = 0; gnt_any = 0;
    repeat (10) begin
      @(negedge clk);
      ctl_or  |= int'({gnt, viol, ack, ram_rd, ram_wr});
      gnt_any |= int'(gnt);
    end
    check_eq("reset_ctl", ctl_or, 0);
    check_eq("reset_gnt", gnt_any, 0);
    check_eq("reset_ram_addr", ram_addr, 0);
    check_eq("reset_ram_wdata", ram_wdata, 0);
    check_eq("reset_cfg_rdata", cfg_rdata, 0);
    check_eq("reset_lu_rdata", lu_rdata, 0);

    // Basic write then read-back
    d = make_entry(14'h0005, 48'h0A0B0C0D0E0F);
    cfg_op(1'b1, 8'h00, d, 2);
    cfg_op(1'b0, 8'h00, '0, 4);
    check_eq("rd0_const", cfg_rdata, 62'h0005_0A0B0C0D0E0F);

    // Contention right after reset: lookup first, then cfg; later contention after a session: cfg first
    do_reset();
    a0 = ack_cnt;
    fork
      begin
        lu_grant(lat);
        check_eq("fair1_lu_lat", lat, 2);
        check_eq("fair1_no_ack_before_gnt", ack_cnt - a0, 0);
        w0 = wr_cnt;
        lu_reads(3, 1'b0, 8'h00);
        check_eq("fair1_no_wr_in_session", wr_cnt - w0, 0);
        lu_end();
      end
      cfg_op(1'b1, 8'h10, make_entry(14'h1234, 48'h112233445566), -1);
    join
    lu_grant(lat);
    check_eq("solo_lu_lat", lat, 2);
    lu_reads(2, 1'b0, 8'h10);
    lu_end();
    a0 = ack_cnt;
    fork
      begin
        lu_grant(lat);
        check_eq("fair2_lu_lat", lat, 4);
        check_eq("fair2_ack_before_gnt", ack_cnt - a0, 1);
        lu_reads(2, 1'b0, 8'h11);
        lu_end();
      end
      cfg_op(1'b1, 8'h11, make_entry(14'h3FFF, 48'hFFFFFFFFFFFF), 2);
    join

    // Config write arriving mid-session waits; it then wins over a re-raised lookup
    fork
      begin
        lu_grant(lat);
        check_eq("mid_lu_lat", lat, 2);
        w0 = wr_cnt;
        lu_reads(3, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        check_eq("mid_no_wr_in_session", wr_cnt - w0, 0);
        lu_end();
        a0 = ack_cnt;
        lu_grant(lat);
        check_eq("mid_regrant_lat", lat, 4);
        check_eq("mid_wr_before_regrant", ack_cnt - a0, 1);
        lu_end();
      end
      begin
        repeat (2) @(posedge clk);
        cfg_op(1'b1, 8'h05, make_entry(14'h0ABC, 48'hDEADBEEF0001), -1);
      end
    join

    // Randomized mix of writes, reads and lookup sessions
    for (int it = 0; it < 40; it++) begin
      int op;
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        cfg_op(1'b1, AW'($urandom_range(0, 15)), {30'($urandom), $urandom}, 2);
      end else if (op == 1) begin
        cfg_op(1'b0, AW'($urandom_range(0, 15)), '0, 4);
      end else begin
        lu_grant(lat);
        check_eq("rnd_lu_lat", lat, 2);
        lu_reads(int'($urandom_range(1, 6)), 1'b1, 8'h00);
        lu_end();
      end
    end

    // Lookup strobe without a grant
    @(negedge clk);
    check_eq("viol_clean", viol, 0);
    @(posedge clk); #1 lu_rd = 1'b1; lu_raddr = 8'h03;
    @(negedge clk);
    check_eq("viol_no_ram_rd", ram_rd, 0);
    @(posedge clk); #1 lu_rd = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("viol_sticky", viol, 1);
    do_reset();
    @(negedge clk);
    check_eq("viol_cleared_by_reset", viol, 0);

`ifdef INVMAP_TABLE_CLEAR_EN
    begin
      int busy_n, wr_n, ack_n;
      bit seq_ok;
      cfg_op(1'b1, 8'hFF, make_entry(14'h0001, 48'h000000000001), 2);
      busy_n = 0; wr_n = 0; ack_n = 0; seq_ok = 1'b1;
      @(posedge clk); #1 cfg_clear = 1'b1;
      @(posedge clk); #1 cfg_clear = 1'b0;
      repeat (300) begin
        @(negedge clk);
        if (clr_busy) busy_n++;
        if (ack) ack_n++;
        if (ram_wr) begin
          if (ram_addr !== AW'(wr_n) || ram_wdata !== '0) seq_ok = 1'b0;
          wr_n++;
        end
      end
      check_eq("clr_busy_cycles", busy_n, DEPTH);
      check_eq("clr_write_count", wr_n, DEPTH);
      check_eq("clr_write_seq", seq_ok, 1);
      check_eq("clr_single_ack", ack_n, 1);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      cfg_op(1'b0, 8'hFF, '0, 4);

      @(posedge clk); #1 cfg_clear = 1'b1;
      @(posedge clk); #1 cfg_clear = 1'b0;
      repeat (50) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("clr_rst_outputs", {clr_busy, ram_wr, ack, gnt}, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      a0 = ack_cnt;
      repeat (300) @(negedge clk);
      check_eq("clr_rst_no_ack", ack_cnt - a0, 0);
      do_reset();
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_inversemapping_table_arbiter
`default_nettype wire
